// File: rtl/ps2_scan_if.sv
// Scancode bundle from the PS/2 receiver to the keyboard display stage.
// master drives the decoded byte and its strobes; slave consumes them.
interface ps2_scan_if;
  logic [7:0] displayData;
  logic [7:0] scanCode;
  logic       scanValid;
  logic       breakFlag;
  logic       extFlag;
  logic       frameErr;

  modport master (
    output displayData, scanCode, scanValid,
    output breakFlag, extFlag, frameErr
  );

  modport slave (
    input displayData, scanCode, scanValid,
    input breakFlag, extFlag, frameErr
  );
endinterface

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix handling.
// Raw pins are synchronised, the clock is glitch filtered, bits taken on falls.
module ps2_scan_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  ps2_scan_if.master scan
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0]    ck_s;
  logic [1:0]    dt_s;
  logic          fclk;
  logic          fclk_q;
  logic [FW-1:0] fcnt;
  logic          strobe;
  logic          sample;
  logic          good;

  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tocnt;
  logic          brk_p;
  logic          ext_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_s <= 2'b11;
      dt_s <= 2'b11;
    end else begin
      ck_s <= {ck_s[0], ps2Clk};
      dt_s <= {dt_s[0], ps2Data};
    end
  end

  // Level only moves after FILTER_LEN agreeing samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fclk   <= 1'b1;
      fclk_q <= 1'b1;
      fcnt   <= '0;
    end else begin
      fclk_q <= fclk;
      if (ck_s[1] == fclk) begin
        fcnt <= '0;
      end else if (fcnt == F_LAST) begin
        fclk <= ck_s[1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign strobe = fclk_q & ~fclk;
  assign sample = dt_s[1];
  assign good   = sample & (^shreg ^ par);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      bitcnt           <= '0;
      shreg            <= '0;
      par              <= 1'b0;
      tocnt            <= '0;
      brk_p            <= 1'b0;
      ext_p            <= 1'b0;
      scan.displayData <= '0;
      scan.scanCode    <= '0;
      scan.scanValid   <= 1'b0;
      scan.breakFlag   <= 1'b0;
      scan.extFlag     <= 1'b0;
      scan.frameErr    <= 1'b0;
    end else begin
      scan.scanValid <= 1'b0;
      scan.frameErr  <= 1'b0;

      if (state == IDLE || strobe) begin
        tocnt <= '0;
      end else if (tocnt != T_LAST) begin
        tocnt <= tocnt + 1'b1;
      end

      // A stalled device abandons the frame silently.
      if (state != IDLE && !strobe && tocnt == T_LAST) begin
        state <= IDLE;
        brk_p <= 1'b0;
        ext_p <= 1'b0;
      end else if (strobe) begin
        unique case (state)
          IDLE: begin
            if (!sample) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg[bitcnt] <= sample;
            bitcnt        <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= sample;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!good) begin
              scan.frameErr <= 1'b1;
              brk_p         <= 1'b0;
              ext_p         <= 1'b0;
            end else if (shreg == 8'hF0) begin
              brk_p <= 1'b1;
            end else if (shreg == 8'hE0) begin
              ext_p <= 1'b1;
            end else begin
              scan.scanCode  <= shreg;
              scan.breakFlag <= brk_p;
              scan.extFlag   <= ext_p;
              scan.scanValid <= 1'b1;
              brk_p          <= 1'b0;
              ext_p          <= 1'b0;
              if (!brk_p) scan.displayData <= shreg;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: frames, prefixes, errors,
// timeout, clock glitches and mid-frame reset.
module tb_ps2_scan_receiver;

  localparam int FL = 4;
  localparam int TO = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2Clk = 1'b1;
  logic ps2Data = 1'b1;

  ps2_scan_if scan ();

  ps2_scan_receiver #(
    .FILTER_LEN(FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ps2Clk(ps2Clk),
    .ps2Data(ps2Data),
    .scan(scan.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nsv = 0;
  int nfe = 0;
  int both = 0;
  int bsv;
  int bfe;
  logic first_brk;

  always @(negedge clk) begin
    if (scan.scanValid) nsv++;
    if (scan.frameErr) nfe++;
    if (scan.scanValid && scan.frameErr) both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mkf(input logic [7:0] b,
                                      input logic bp, input logic bs);
    return {~bs, (~^b) ^ bp, b, 1'b0};
  endfunction

  // Device drives data while clock high; host samples on the fall.
  task automatic send_bits(input logic [10:0] f, input int lo,
                           input int hi, input int gl);
    for (int i = lo; i < hi; i++) begin
      ps2Data = f[i];
      cyc(10);
      ps2Clk = 1'b0;
      cyc(20);
      ps2Clk = 1'b1;
      if (i == gl) begin
        cyc(4);
        ps2Clk = 1'b0;
        cyc(2);
        ps2Clk = 1'b1;
        cyc(4);
      end else begin
        cyc(10);
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(mkf(b, 1'b0, 1'b0), 0, 11, -1);
    ps2Data = 1'b1;
    cyc(20);
  endtask

  task automatic send_bad(input logic [7:0] b, input logic bp,
                          input logic bs);
    send_bits(mkf(b, bp, bs), 0, 11, -1);
    ps2Data = 1'b1;
    cyc(20);
  endtask

  initial begin
    cyc(5);
    chk("rst_disp", scan.displayData, 8'h00);
    chk("rst_code", scan.scanCode, 8'h00);
    chk("rst_valid", scan.scanValid, 1'b0);
    chk("rst_flags", {scan.breakFlag, scan.extFlag, scan.frameErr}, 3'b000);
    rst_n = 1'b1;
    cyc(10);

    bsv = nsv;
    send(8'h1C);
    chk("1c_cnt", nsv - bsv, 1);
    chk("1c_code", scan.scanCode, 8'h1C);
    chk("1c_disp", scan.displayData, 8'h1C);
    chk("1c_flags", {scan.breakFlag, scan.extFlag}, 2'b00);
    chk("1c_ferr", nfe, 0);

    bsv = nsv;
    send(8'h32);
    first_brk = scan.breakFlag;
    send(8'hF0);
    send(8'h32);
    chk("32_cnt", nsv - bsv, 2);
    chk("32_brk0", first_brk, 1'b0);
    chk("32_brk1", scan.breakFlag, 1'b1);
    chk("32_disp", scan.displayData, 8'h32);

    send(8'h1C);
    chk("1c2_disp", scan.displayData, 8'h1C);
    send(8'hF0);
    send(8'h1C);
    chk("1c2_brk", scan.breakFlag, 1'b1);
    chk("1c2_hold", scan.displayData, 8'h1C);

    bsv = nsv;
    send(8'hE0);
    send(8'h75);
    chk("e0_cnt", nsv - bsv, 1);
    chk("e0_code", scan.scanCode, 8'h75);
    chk("e0_flags", {scan.breakFlag, scan.extFlag}, 2'b01);
    chk("e0_disp", scan.displayData, 8'h75);

    send(8'h1C);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("e0f0_flags", {scan.breakFlag, scan.extFlag}, 2'b11);
    chk("e0f0_disp", scan.displayData, 8'h1C);

    bsv = nsv;
    bfe = nfe;
    send_bad(8'h2B, 1'b1, 1'b0);
    chk("par_ferr", nfe - bfe, 1);
    chk("par_cnt", nsv - bsv, 0);
    chk("par_disp", scan.displayData, 8'h1C);
    send_bad(8'h2B, 1'b0, 1'b1);
    chk("stop_ferr", nfe - bfe, 2);
    chk("stop_cnt", nsv - bsv, 0);
    chk("stop_disp", scan.displayData, 8'h1C);
    send(8'h2B);
    chk("2b_code", scan.scanCode, 8'h2B);
    chk("2b_disp", scan.displayData, 8'h2B);

    send(8'hF0);
    send_bad(8'h1C, 1'b1, 1'b0);
    send(8'h2B);
    chk("f0err_brk", scan.breakFlag, 1'b0);

    bsv = nsv;
    bfe = nfe;
    send_bits(mkf(8'h4D, 1'b0, 1'b0), 0, 5, -1);
    ps2Data = 1'b1;
    cyc(TO + 10);
    chk("to_cnt", nsv - bsv, 0);
    chk("to_ferr", nfe - bfe, 0);
    send(8'h4D);
    chk("4d_cnt", nsv - bsv, 1);
    chk("4d_code", scan.scanCode, 8'h4D);
    chk("4d_flags", {scan.breakFlag, scan.extFlag}, 2'b00);

    bsv = nsv;
    bfe = nfe;
    ps2Clk = 1'b0;
    cyc(2);
    ps2Clk = 1'b1;
    cyc(10);
    send_bits(mkf(8'h5A, 1'b0, 1'b0), 0, 11, 4);
    ps2Data = 1'b1;
    cyc(20);
    chk("gl_cnt", nsv - bsv, 1);
    chk("gl_ferr", nfe - bfe, 0);
    chk("gl_code", scan.scanCode, 8'h5A);

    bsv = nsv;
    bfe = nfe;
    send_bits(mkf(8'h16, 1'b0, 1'b0), 0, 6, -1);
    ps2Data = 1'b0;
    cyc(10);
    ps2Clk = 1'b0;
    cyc(5);
    rst_n = 1'b0;
    #1;
    chk("mr_disp", scan.displayData, 8'h00);
    chk("mr_code", scan.scanCode, 8'h00);
    chk("mr_out", {scan.scanValid, scan.breakFlag,
                   scan.extFlag, scan.frameErr}, 4'h0);
    cyc(5);
    rst_n = 1'b1;
    cyc(10);
    ps2Clk = 1'b1;
    cyc(10);
    send_bits(mkf(8'h16, 1'b0, 1'b0), 7, 11, -1);
    ps2Data = 1'b1;
    cyc(TO + 10);
    chk("mr_cnt", nsv - bsv, 0);
    chk("mr_ferr", nfe - bfe, 0);
    send(8'h16);
    chk("16_cnt", nsv - bsv, 1);
    chk("16_disp", scan.displayData, 8'h16);
    chk("16_code", scan.scanCode, 8'h16);

    chk("never_both", both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
